// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard sequencer.
// Holds the FSM state encoding, the x0 register index and the per-stage control pair.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic stall;
    logic flush;
  } stageCtrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the operands read in ID.
// A load to x0 never creates a hazard because x0 is hardwired to zero.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  output logic       loadUse
);

  assign loadUse = exMemRead && (exRd != REG_ZERO) &&
                   ((exRd == idRs1) || (exRd == idRs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes,
// data-memory wait stalls with a timeout error state, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT    = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   ex_memRead,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_branchTaken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   err_clear,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_stall,
  output logic                   id_ex_flush,
  output logic                   ex_mem_stall,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_stall,
  output logic                   mem_wb_flush,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  hazState_t         state, nextState;
  logic [WAIT_W-1:0] waitCnt, nextWaitCnt;
  logic              loadUse;
  logic              memWait;
  logic              pcStall;
  stageCtrl_t        ifIdCtrl, idExCtrl, exMemCtrl, memWbCtrl;

  hazard_detect uHazardDetect (
    .idRs1     (id_rs1),
    .idRs2     (id_rs2),
    .exMemRead (ex_memRead),
    .exRd      (ex_rd),
    .loadUse   (loadUse)
  );

  assign memWait = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= nextState;
      waitCnt     <= nextWaitCnt;
      mem_timeout <= (nextState == ERROR);
    end
  end

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    case (state)
      RUN: begin
        if (memWait) begin
          nextState   = MEM_WAIT;
          nextWaitCnt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!memWait) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end else if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
          nextState = ERROR;
        end else begin
          nextWaitCnt = waitCnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        if (err_clear) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end
      end
      default: begin
        nextState   = RUN;
        nextWaitCnt = '0;
      end
    endcase
  end

  // Priority mux; forced quiet while reset is held so the pipeline sees no stray stalls.
  always_comb begin
    pcStall   = 1'b0;
    ifIdCtrl  = '0;
    idExCtrl  = '0;
    exMemCtrl = '0;
    memWbCtrl = '0;
    if (!reset) begin
      pcStall = 1'b0;
    end else if (state == ERROR || memWait) begin
      pcStall         = 1'b1;
      ifIdCtrl.stall  = 1'b1;
      idExCtrl.stall  = 1'b1;
      exMemCtrl.stall = 1'b1;
      memWbCtrl.flush = 1'b1;
    end else if (ex_branchTaken) begin
      ifIdCtrl.flush = 1'b1;
      idExCtrl.flush = 1'b1;
    end else if (loadUse) begin
      pcStall        = 1'b1;
      ifIdCtrl.stall = 1'b1;
      idExCtrl.flush = 1'b1;
    end
  end

  assign pc_stall     = pcStall;
  assign if_id_stall  = ifIdCtrl.stall;
  assign if_id_flush  = ifIdCtrl.flush;
  assign id_ex_stall  = idExCtrl.stall;
  assign id_ex_flush  = idExCtrl.flush;
  assign ex_mem_stall = exMemCtrl.stall;
  assign ex_mem_flush = exMemCtrl.flush;
  assign mem_wb_stall = memWbCtrl.stall;
  assign mem_wb_flush = memWbCtrl.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (pcStall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table of single-cycle cases plus
// hand-written sequences for memory waits, timeout, branch-in-wait and reset mid-wait.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int MAX_WAIT    = 4;
  localparam int STALL_CNT_W = 4;
  localparam logic [8:0] STALL_PAT = 9'b110101001;
  localparam logic [8:0] BR_PAT    = 9'b001010000;
  localparam logic [8:0] LU_PAT    = 9'b110010000;

  logic clk, reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_memRead, ex_branchTaken, mem_req, mem_ready, err_clear;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_timeout;
  logic [STALL_CNT_W-1:0] stall_count;

  int vecCount = 0;
  int missCount = 0;
  int expCount = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memRead;
    logic       branch;
    logic       req;
    logic       ready;
    logic [8:0] expOuts;
  } vec_t;

  vec_t vecs [12];

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branchTaken(ex_branchTaken), .mem_req(mem_req), .mem_ready(mem_ready),
    .err_clear(err_clear),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};
  endfunction

  function automatic int satCnt(int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_rs1         = v.rs1;
    id_rs2         = v.rs2;
    ex_rd          = v.rd;
    ex_memRead     = v.memRead;
    ex_branchTaken = v.branch;
    mem_req        = v.req;
    mem_ready      = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    applyStimulus('0);
    err_clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs1, rs2, rd, memRead, branch, req, ready, expected outputs
    vecs[0]  = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, LU_PAT};
    vecs[1]  = '{5'd5,  5'd6,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 9'b0};
    vecs[2]  = '{5'd0,  5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 9'b0};
    vecs[3]  = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, BR_PAT};
    vecs[4]  = '{5'd9,  5'd2,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LU_PAT};
    vecs[5]  = '{5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 9'b0};
    vecs[6]  = '{5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b1, 1'b1, BR_PAT};
    vecs[7]  = '{5'd4,  5'd2,  5'd4,  1'b1, 1'b1, 1'b1, 1'b0, STALL_PAT};
    vecs[8]  = '{5'd4,  5'd2,  5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 9'b0};
    vecs[9]  = '{5'd8,  5'd8,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 9'b0};
    vecs[10] = '{5'd3,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, LU_PAT};
    vecs[11] = '{5'd3,  5'd4,  5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 9'b0};

    // Hazard-causing inputs during reset must not leak onto the outputs.
    reset = 1'b0;
    clearInputs();
    mem_req = 1'b1;
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #12;
    checkOutput("reset_outs", 32'(outs()), 32'd0);
    checkOutput("reset_count", 32'(stall_count), 32'd0);
    checkOutput("reset_timeout", 32'(mem_timeout), 32'd0);
    clearInputs();
    #1 reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].expOuts));
      tick();
      expCount += int'(vecs[i].expOuts[8]);
      checkOutput($sformatf("vec%0d_count", i), 32'(stall_count), 32'(satCnt(expCount)));
    end
    clearInputs();

    // Three wait cycles then ready.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 checkOutput($sformatf("wait%0d_outs", i), 32'(outs()), 32'(STALL_PAT));
      tick();
      expCount++;
    end
    mem_ready = 1'b1;
    #2 checkOutput("wait_ready_outs", 32'(outs()), 32'd0);
    tick();
    checkOutput("wait_state", 32'(dut.state), 32'(RUN));
    checkOutput("wait_count", 32'(stall_count), 32'(satCnt(expCount)));
    clearInputs();

    // Branch and load-use held off during the wait, branch taken on the ready cycle.
    mem_req = 1'b1; ex_branchTaken = 1'b1;
    ex_memRead = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #2 checkOutput($sformatf("brwait%0d_outs", i), 32'(outs()), 32'(STALL_PAT));
      tick();
      expCount++;
    end
    mem_ready = 1'b1; ex_memRead = 1'b0;
    #2 checkOutput("brwait_ready_outs", 32'(outs()), 32'(BR_PAT));
    tick();
    clearInputs();

    // Timeout after MAX_WAIT wait cycles, held in ERROR until err_clear.
    mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #2 checkOutput($sformatf("tmo%0d_outs", i), 32'(outs()), 32'(STALL_PAT));
      tick();
      expCount++;
      checkOutput($sformatf("tmo%0d_flag", i), 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
    end
    #2 checkOutput("err_outs", 32'(outs()), 32'(STALL_PAT));
    tick();
    expCount++;
    mem_req = 1'b0;
    #2 checkOutput("err_noreq_outs", 32'(outs()), 32'(STALL_PAT));
    tick();
    expCount++;
    checkOutput("err_flag_hold", 32'(mem_timeout), 32'd1);
    err_clear = 1'b1;
    #2 checkOutput("err_clear_outs", 32'(outs()), 32'(STALL_PAT));
    tick();
    expCount++;
    err_clear = 1'b0;
    #2;
    checkOutput("cleared_flag", 32'(mem_timeout), 32'd0);
    checkOutput("cleared_outs", 32'(outs()), 32'd0);
    checkOutput("cleared_state", 32'(dut.state), 32'(RUN));
    checkOutput("sat_count", 32'(stall_count), 32'(satCnt(expCount)));
    ex_memRead = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6;
    tick();
    expCount++;
    checkOutput("sat_hold", 32'(stall_count), 32'(satCnt(expCount)));
    clearInputs();

    // Asynchronous reset while waiting on memory.
    mem_req = 1'b1;
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    checkOutput("rstwait_outs", 32'(outs()), 32'd0);
    checkOutput("rstwait_count", 32'(stall_count), 32'd0);
    checkOutput("rstwait_timeout", 32'(mem_timeout), 32'd0);
    mem_req = 1'b0;
    #2 reset = 1'b1;
    tick();
    checkOutput("rstwait_state", 32'(dut.state), 32'(RUN));
    checkOutput("rstwait_after_outs", 32'(outs()), 32'd0);
    ex_memRead = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2;
    tick();
    checkOutput("rstwait_recount", 32'(stall_count), 32'd1);
    clearInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, with a wait-timeout error state and a saturating stall-cycle counter.
- Sits beside the datapath; it takes inputs from the ID, EX and MEM stages and the data-memory handshake.

Parameters:
- MAX_WAIT, 16: maximum consecutive data-memory wait cycles before the error state; legal range is 2 or more.
- STALL_CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- ex_memRead  in  1  the ID/EX instruction is a load.
- ex_rd  in  5  destination register of the ID/EX instruction.
- ex_branchTaken  in  1  a branch or jump resolved taken in EX.
- mem_req  in  1  the EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- err_clear  in  1  pulse that leaves the ERROR state.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  stall the IF/ID register.
- if_id_flush  out  1  flush the IF/ID register.
- id_ex_stall  out  1  stall the ID/EX register.
- id_ex_flush  out  1  flush the ID/EX register.
- ex_mem_stall  out  1  stall the EX/MEM register.
- ex_mem_flush  out  1  flush the EX/MEM register.
- mem_wb_stall  out  1  stall the MEM/WB register.
- mem_wb_flush  out  1  flush the MEM/WB register.
- mem_timeout  out  1  registered; high while in ERROR.
- stall_count  out  STALL_CNT_W  registered, saturating count of cycles with pc_stall=1.

Behaviour:
- Reset: asynchronous while reset=0. state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0. All stall/flush outputs are 0 during reset.
- Stall/flush outputs are combinational from the current state and inputs. Pipeline registers sample them at the next posedge, so there is zero added latency.
- Conditions:
  - load_use = ex_memRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - mem_wait = mem_req && !mem_ready.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when mem_wait. wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready. wait_cnt<=0.
  - MEM_WAIT stays in MEM_WAIT when mem_wait and wait_cnt<MAX_WAIT-1. wait_cnt increments.
  - MEM_WAIT -> ERROR when mem_wait and wait_cnt==MAX_WAIT-1. The error state is therefore entered after MAX_WAIT consecutive wait cycles.
  - MEM_WAIT -> RUN when mem_req drops. wait_cnt<=0.
  - ERROR -> RUN on err_clear=1. wait_cnt<=0. Otherwise the FSM stays in ERROR.
- Output priority, highest first:
  1. ERROR: pc, if_id, id_ex and ex_mem stall=1; mem_wb_flush=1; all other outputs 0.
  2. mem_wait (in RUN or MEM_WAIT): pc, if_id, id_ex and ex_mem stall=1; mem_wb_flush=1 so WB receives a bubble. A branch or load-use in the same cycle is ignored; it is re-evaluated once the stall lifts, because ID/EX is held.
  3. ex_branchTaken: if_id_flush=1 and id_ex_flush=1; pc not stalled, so the PC loads the target. Overrides a simultaneous load_use, because the ID instruction is squashed anyway.
  4. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1. Exactly one bubble per hazard, since the load then moves to EX/MEM.
  5. Otherwise all outputs are 0.
- ex_mem_flush and mem_wb_stall are always 0 in this revision. They are reserved and driven 0.
- stall_count increments at each posedge where pc_stall=1 and saturates at all-ones.
- reset asserted mid-wait or in ERROR: immediate return to RUN with counters cleared.

Decomposition:
- A shared package pipeline_pkg holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - REG_ZERO=5'd0;
  - a packed stage-control struct {stall, flush}.
- One sub-module, hazard_detect: the combinational load_use compare. The FSM, counters and priority mux stay in the top module.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, no mem_req -> for one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle, with ex_memRead=0, all outputs are 0 and stall_count=1.
- x0 load and branch precedence:
  - ex_rd=0 matching id_rs1=0 -> no stall.
  - ex_branchTaken=1 together with a load_use match -> if_id_flush=1 and id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> stalls and mem_wb_flush for exactly 3 cycles, state back in RUN, stall_count=3.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready=0 held -> mem_timeout=1 after the 4th posedge. Stalls are held. err_clear pulse -> RUN, mem_timeout=0.
- Branch during wait: mem_wait and ex_branchTaken both high -> no flush while waiting. On the mem_ready cycle, if_id_flush=1 and id_ex_flush=1.
- Reset mid-wait: reset=0 asserted asynchronously in MEM_WAIT -> outputs go to 0 immediately, stall_count=0, state RUN after release.
